// File: rtl/ysyx_23060332_regfile_sb_if.sv
// Register file bus bundle: read ports, issue/scoreboard side, writeback side.
//   master: IDU/EXU/WBU side (drives addresses, issue, writeback, flush)
//   slave : register file (drives rdata, rbusy, issue_ready, init_done)
// Parameters must match the register file instance: DW data width,
// AW register address width, NR number of read ports.
interface ysyx_23060332_regfile_sb_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
);
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;
  logic             issue_ready;
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic             flush;
  logic             init_done;

  modport master (
    output raddr, issue_valid, issue_rd, wen, waddr, wdata, flush,
    input  rdata, rbusy, issue_ready, init_done
  );

  modport slave (
    input  raddr, issue_valid, issue_rd, wen, waddr, wdata, flush,
    output rdata, rbusy, issue_ready, init_done
  );
endinterface

// File: rtl/ysyx_23060332_regfile_sb.sv
// Integer register file with scoreboard and self-clearing init sequencer.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous, active-high reset (restarts the init sweep)
//   bus  : ysyx_23060332_regfile_sb_if.slave
//          NR combinational read ports (rdata/rbusy), one write port
//          (wen/waddr/wdata), destination issue (issue_valid/issue_rd),
//          flush, issue_ready/init_done status.
// Entry 0 is hardwired zero and never busy.
// Optional feature: define YSYX_23060332_REGFILE_BYPASS_EN to forward the
// writeback data and busy-clear to matching read ports in the same cycle.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_INIT | sweeping regs[1..DEPTH-1] to zero, one per cycle
// ST_RUN  | normal operation; reads, writes and scoreboard active
module ysyx_23060332_regfile_sb #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int NR    = 2
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_23060332_regfile_sb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic            run;
  logic            wr_en;

  assign run   = (state_q == ST_RUN);
  assign wr_en = run && bus.wen && (bus.waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
    end
  end

  // The array itself is not touched while rst is held; the sweep clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) regs_q[cnt_q] <= '0;
      else if (wr_en) regs_q[bus.waddr] <= bus.wdata;
    end
  end

  // Priority per bit: flush > issue set > writeback clear.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      for (int r = 1; r < DEPTH; r++) begin
        if (wr_en && (bus.waddr == AW'(r))) busy_d[r] = 1'b0;
        if (bus.issue_valid && (bus.issue_rd == AW'(r))) busy_d[r] = 1'b1;
      end
    end
    if (bus.flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          rb;

    assign ra = bus.raddr[k*AW +: AW];

    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (run && (ra != '0)) begin
        rd = regs_q[ra];
        rb = busy_q[ra];
`ifdef YSYX_23060332_REGFILE_BYPASS_EN
        // A same-cycle issue to this register is a newer producer, so it
        // keeps the port busy even though the old value is being forwarded.
        if (wr_en && (bus.waddr == ra)) begin
          rd = bus.wdata;
          rb = bus.issue_valid && (bus.issue_rd == ra);
        end
`else
`endif
      end
    end

    assign bus.rdata[k*DW +: DW] = rd;
    assign bus.rbusy[k]          = rb;
  end

  assign bus.init_done   = run;
  assign bus.issue_ready = run;

endmodule

// File: tb/tb_ysyx_23060332_regfile_sb.sv
module tb_ysyx_23060332_regfile_sb;
  localparam int DW = 32, DEPTH = 32, AW = 5, NR = 3;

`ifdef YSYX_23060332_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060332_regfile_sb_if #(.DW(DW), .AW(AW), .NR(NR)) bus();

  ysyx_23060332_regfile_sb #(.DW(DW), .DEPTH(DEPTH), .NR(NR)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic [4:0]  ra0, ra1, ra2;
    logic [31:0] e0, e1, e2;
    logic [2:0]  eb;
  } vec_t;

  vec_t vecs [18];

  logic [31:0] mregs [DEPTH];
  logic [31:0] mbusy;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.wen         = 1'b0;
    bus.waddr       = '0;
    bus.wdata       = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ird, input logic fl,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    bus.wen         = w;
    bus.waddr       = wa;
    bus.wdata       = wd;
    bus.issue_valid = iv;
    bus.issue_rd    = ird;
    bus.flush       = fl;
    bus.raddr       = {r2, r1, r0};
  endtask

  // Expected read of one port from the reference state, with forwarding if built in.
  task automatic exp_port(input logic [4:0] a, output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (a != 0) begin
      d = mregs[a];
      b = mbusy[a];
      if (BYP && bus.wen && bus.waddr != 0 && bus.waddr == a) begin
        d = bus.wdata;
        b = bus.issue_valid && (bus.issue_rd == a);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d0, d1, d2, f0, f1, f2;
    logic [2:0]  eb;
    logic        b0, b1, b2;
    logic [4:0]  r0, r1, r2;

    // wen wa wdata iv ird fl ra0 ra1 ra2 e0 e1 e2 eb  (no-forwarding expectations)
    vecs[0]  = '{1'b1, 5'd3,  32'h12345678, 1'b0, 5'd0, 1'b0, 5'd3,  5'd0, 5'd0, 32'h0,        32'h0,  32'h0,        3'b000};
    vecs[1]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd3,  5'd0, 5'd0, 32'h12345678, 32'h0,  32'h0,        3'b000};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 1'b0, 5'd7,  5'd0, 5'd0, 32'h0,        32'h0,  32'h0,        3'b000};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd7,  5'd0, 5'd0, 32'h0,        32'h0,  32'h0,        3'b001};
    vecs[4]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd7,  5'd0, 5'd0, 32'h0,        32'h0,  32'h0,        3'b001};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd7,  5'd0, 5'd0, 32'hA5A5A5A5, 32'h0,  32'h0,        3'b000};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 1'b0, 5'd0,  5'd9, 5'd0, 32'h0,        32'h0,  32'h0,        3'b000};
    vecs[7]  = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd9, 1'b0, 5'd0,  5'd9, 5'd0, 32'h0,        32'h0,  32'h0,        3'b010};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  5'd9, 5'd0, 32'h0,        32'h99, 32'h0,        3'b010};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4, 1'b1, 5'd4,  5'd9, 5'd0, 32'h0,        32'h99, 32'h0,        3'b010};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd4,  5'd9, 5'd7, 32'h0,        32'h99, 32'hA5A5A5A5, 3'b000};
    vecs[11] = '{1'b1, 5'd1,  32'h1,        1'b0, 5'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h0,        32'h0,  32'h0,        3'b000};
    vecs[12] = '{1'b1, 5'd2,  32'h2,        1'b0, 5'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'h0,        32'h0,  32'h0,        3'b000};
    vecs[13] = '{1'b1, 5'd31, 32'h31,       1'b0, 5'd0, 1'b0, 5'd31, 5'd2, 5'd1, 32'h0,        32'h2,  32'h1,        3'b000};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd31, 5'd2, 5'd1, 32'h31,       32'h2,  32'h1,        3'b000};
    vecs[15] = '{1'b1, 5'd5,  32'h55,       1'b0, 5'd0, 1'b0, 5'd5,  5'd0, 5'd0, 32'h0,        32'h0,  32'h0,        3'b000};
    vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd5,  5'd0, 5'd0, 32'h55,       32'h0,  32'h0,        3'b000};
    vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b1, 5'd3,  5'd0, 5'd0, 32'h12345678, 32'h0,  32'h0,        3'b000};

    // ---------------- reset and init sweep ----------------
    rst = 1'b1;
    idle();
    bus.raddr = {5'd5, 5'd5, 5'd5};
    @(negedge clk);
    step();
    step();
    #1;
    chk("reset_init_done", 128'(bus.init_done), 128'(0));
    chk("reset_issue_ready", 128'(bus.issue_ready), 128'(0));
    chk("reset_rbusy", 128'(bus.rbusy), 128'(0));
    chk("reset_rdata", 128'(bus.rdata), 128'(0));

    // Writes and issues during init must be dropped.
    bus.wen = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEAD;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd6;
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("partial_init_done", 128'(bus.init_done), 128'(0));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.raddr = {5'd0, 5'd5, 5'd6};
    for (int e = 1; e <= 31; e++) begin
      step();
      if (e == 31) idle();
      #1;
      chk($sformatf("init_done_edge%0d", e), 128'(bus.init_done), 128'(e == 31));
      chk($sformatf("issue_ready_edge%0d", e), 128'(bus.issue_ready), 128'(e == 31));
      chk($sformatf("init_rdata_edge%0d", e), 128'(bus.rdata), 128'(0));
    end
    chk("post_init_x5_x6_rdata", 128'(bus.rdata), 128'(0));
    chk("post_init_x6_rbusy", 128'(bus.rbusy), 128'(0));

    // ---------------- directed vector table ----------------
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].iv, vecs[i].ird, vecs[i].fl,
            vecs[i].ra0, vecs[i].ra1, vecs[i].ra2);
      d0 = vecs[i].e0; d1 = vecs[i].e1; d2 = vecs[i].e2; eb = vecs[i].eb;
      if (BYP && vecs[i].wen && vecs[i].waddr != 0) begin
        if (vecs[i].waddr == vecs[i].ra0) begin d0 = vecs[i].wdata; eb[0] = vecs[i].iv && vecs[i].ird == vecs[i].ra0; end
        if (vecs[i].waddr == vecs[i].ra1) begin d1 = vecs[i].wdata; eb[1] = vecs[i].iv && vecs[i].ird == vecs[i].ra1; end
        if (vecs[i].waddr == vecs[i].ra2) begin d2 = vecs[i].wdata; eb[2] = vecs[i].iv && vecs[i].ird == vecs[i].ra2; end
      end
      #1;
      chk($sformatf("vec%0d_rdata", i), 128'(bus.rdata), 128'({d2, d1, d0}));
      chk($sformatf("vec%0d_rbusy", i), 128'(bus.rbusy), 128'(eb));
      step();
    end
    idle();

    // ---------------- reset from RUN, then random vs. reference ----------------
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      step();
      if (e == 30 || e == 31) begin
        #1;
        chk($sformatf("reinit_done_edge%0d", e), 128'(bus.init_done), 128'(e == 31));
      end
    end
    for (int r = 0; r < DEPTH; r++) mregs[r] = '0;
    mbusy = '0;

    for (int c = 0; c < 10000; c++) begin
      r0 = 5'($urandom_range(0, 31));
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 15) == 0), r0, r1, r2);
      if ($urandom_range(0, 3) == 0) bus.waddr = r0;
      #1;
      exp_port(r0, f0, b0);
      exp_port(r1, f1, b1);
      exp_port(r2, f2, b2);
      chk($sformatf("rand%0d_rdata", c), 128'(bus.rdata), 128'({f2, f1, f0}));
      chk($sformatf("rand%0d_rbusy", c), 128'(bus.rbusy), 128'({b2, b1, b0}));
      if (bus.flush) mbusy = '0;
      else begin
        if (bus.wen && bus.waddr != 0) mbusy[bus.waddr] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != 0) mbusy[bus.issue_rd] = 1'b1;
      end
      if (bus.wen && bus.waddr != 0) mregs[bus.waddr] = bus.wdata;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_23060332_regfile_sb.md
# ysyx_23060332_regfile_sb

Parametrised integer register file with NR combinational read ports, one synchronous write port, a per-register scoreboard (busy bits) and a self-clearing init sequencer. It sits between IDU (reads, destination issue) and the EXU/WBU writeback path. It supplies operands, operand-ready status and optional write-to-read forwarding, so the pipeline can stall on RAW hazards.

## Interface
- DW, 32: data width in bits.
- DEPTH, 32: number of registers, power of two, at least 4; entry 0 is hardwired zero.
- AW, $clog2(DEPTH): register address width (derived).
- NR, 2: number of read ports, 1..4.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset: synchronous, active-high; clock clk.
- raddr  input  NR*AW  read addresses; port k is bits [k*AW +: AW].
- rdata  output  NR*DW  read data; port k is bits [k*DW +: DW].
- rbusy  output  NR  port k's register has a pending write (scoreboard bit).
- issue_valid  input  1  IDU issues an instruction that writes issue_rd.
- issue_rd  input  AW  destination register to mark busy.
- issue_ready  output  1  equals init_done; issues are ignored while 0.
- wen  input  1  writeback enable.
- waddr  input  AW  writeback address.
- wdata  input  DW  writeback data.
- flush  input  1  clear all busy bits (pipeline flush).
- init_done  output  1  array clear finished; register file usable.

## Operation
- Two states: INIT and RUN. rst forces INIT with counter cnt=1. This applies from any state, including mid-INIT and mid-RUN.
- INIT: each cycle writes 0 to regs[cnt] and increments cnt. On the cycle that writes DEPTH-1, the next state is RUN.
- In INIT, wen and issue_valid are ignored, rdata reads all-zero and rbusy reads 0.
- RUN: when wen=1 and waddr!=0, regs[waddr] takes wdata at the clock edge. A write to address 0 is discarded.
- Reads are combinational: rdata[k] = regs[raddr[k]]. Address 0 always reads 0 and always has rbusy=0.
- Scoreboard, one bit per register; bit 0 is constant 0. Priority per register at each edge, highest first:
  - rst or flush clears the bit;
  - issue_valid && issue_rd==r sets it;
  - wen && waddr==r clears it.
- Same-cycle writeback and issue to the same register: the bit ends at 1, because the new producer wins.
- rbusy[k] = busy[raddr[k]], subject to bypass (see Configuration).
- Writeback to a register that is not busy is legal: data is written and the busy bit stays 0.

## Timing
- Reset values: init_done=0, issue_ready=0, rbusy=0, rdata=0, all busy bits 0.
- Register contents after reset are all 0 once init_done=1. The array is not cleared during rst itself.
- init_done rises after the (DEPTH-1)th rising edge following the first edge with rst=0. For DEPTH=32, that is edge 31.
- Write-to-read latency: 1 cycle without bypass, 0 cycles with bypass.
- Busy set/clear is visible on rbusy the cycle after the edge that updates it.
- flush has no effect on register contents.

## Configuration
- YSYX_23060332_REGFILE_BYPASS_EN defined: if wen=1, waddr!=0, waddr==raddr[k] and the block is in RUN, then in the same cycle:
  - rdata[k] = wdata;
  - rbusy[k] = 0, unless issue_valid && issue_rd==raddr[k] in that same cycle, in which case rbusy[k] = 1.
- Macro undefined: no forwarding. rdata shows the old value and rbusy shows the registered busy bit until the next edge.

## Test plan
- Init after reset: pulse rst for 2 cycles, then DEPTH=32. Required response:
  - init_done=0 through edge 30 and 1 after edge 31;
  - a wen of 0xDEAD to x5 during INIT is lost, and x5 reads 0;
  - rst asserted mid-INIT restarts the 31-cycle count.
- Write/read and x0: in RUN, write 0x12345678 to x3 and 0xFFFFFFFF to x0, reading x3 on port 0 and x0 on port 1. Required response:
  - port 0 reads 0x12345678 next cycle (same cycle with bypass);
  - port 1 reads 0 and rbusy[1]=0.
- Scoreboard: issue x7; the next cycle, raddr0=7. Required response:
  - rbusy[0]=1;
  - writeback 0xA5A5A5A5 to x7 gives rbusy[0]=0 and rdata=0xA5A5A5A5 the cycle after, or in the same cycle with bypass.
- Simultaneous events and flush:
  - writeback x9 and issue x9 in the same cycle → busy[9]=1;
  - flush together with issue of x4 → all busy bits 0.
- Multi-port: NR=3, write x1=1, x2=2, x31=0x31, then read raddr={31,2,1} → rdata={0x31,2,1}, checked against a reference model over 10k random cycles with random issue, wen and flush.
